pipe_io_in_cond: RTL and testbench



---
 rtl/pipe_io_in_cond.sv | 110 +++++++++++
 tb/tb_pipe_io_in_cond.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_io_in_cond.sv
// Switch input conditioner: 2-flop synchronizer, per-bit debounce and change strobe feeding io_in.
// Define IO_EDGE_LATCH_EN to build the sticky rise/fall edge flags cleared by flag_clr.
module pipe_io_in_cond #(
   parameter int WIDTH           = 10,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] io_in,
   output logic             io_chg,
   output logic [WIDTH-1:0] io_chg_mask,
   input  logic [WIDTH-1:0] flag_clr,
   output logic [WIDTH-1:0] rise_flags,
   output logic [WIDTH-1:0] fall_flags
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_p0_q, sync1_p0_d;
   logic [WIDTH-1:0] sync2_p1_q, sync2_p1_d;
   logic [WIDTH-1:0] io_in_p2_q, io_in_p2_d;
   logic [WIDTH-1:0] chg_mask_p2_q, chg_mask_p2_d;
   logic             chg_p2_q, chg_p2_d;
   logic [CNT_W-1:0] cnt_p2_q [WIDTH];
   logic [CNT_W-1:0] cnt_p2_d [WIDTH];

   // p0 -> p1: synchronizer chain
   always_comb begin
      sync1_p0_d = sw_raw;
      sync2_p1_d = sync1_p0_q;
   end

   // p1 -> p2: debounce against the current stable value
   always_comb begin
      io_in_p2_d    = io_in_p2_q;
      chg_mask_p2_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_p2_d[i] = cnt_p2_q[i];
         if (sync2_p1_q[i] == io_in_p2_q[i]) begin
            cnt_p2_d[i] = '0;
         end else if (cnt_p2_q[i] == CNT_LAST) begin
            io_in_p2_d[i]    = sync2_p1_q[i];
            cnt_p2_d[i]      = '0;
            chg_mask_p2_d[i] = 1'b1;
         end else begin
            cnt_p2_d[i] = cnt_p2_q[i] + CNT_W'(1);
         end
      end
      chg_p2_d = |chg_mask_p2_d;
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         sync1_p0_q    <= '0;
         sync2_p1_q    <= '0;
         io_in_p2_q    <= '0;
         chg_mask_p2_q <= '0;
         chg_p2_q      <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_p2_q[i] <= '0;
         end
      end else begin
         sync1_p0_q    <= sync1_p0_d;
         sync2_p1_q    <= sync2_p1_d;
         io_in_p2_q    <= io_in_p2_d;
         chg_mask_p2_q <= chg_mask_p2_d;
         chg_p2_q      <= chg_p2_d;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_p2_q[i] <= cnt_p2_d[i];
         end
      end
   end

   assign io_in       = io_in_p2_q;
   assign io_chg      = chg_p2_q;
   assign io_chg_mask = chg_mask_p2_q;

`ifdef IO_EDGE_LATCH_EN
   logic [WIDTH-1:0] rise_p2_q, rise_p2_d;
   logic [WIDTH-1:0] fall_p2_q, fall_p2_d;

   // Set is applied after the clear so a coincident acceptance wins.
   always_comb begin
      rise_p2_d = (rise_p2_q & ~flag_clr) | (chg_mask_p2_d &  io_in_p2_d);
      fall_p2_d = (fall_p2_q & ~flag_clr) | (chg_mask_p2_d & ~io_in_p2_d);
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         rise_p2_q <= '0;
         fall_p2_q <= '0;
      end else begin
         rise_p2_q <= rise_p2_d;
         fall_p2_q <= fall_p2_d;
      end
   end

   assign rise_flags = rise_p2_q;
   assign fall_flags = fall_p2_q;
`else
   logic unused_flag_clr;

   assign unused_flag_clr = ^flag_clr;
   assign rise_flags      = '0;
   assign fall_flags      = '0;
`endif

endmodule

// File: tb/tb_pipe_io_in_cond.sv
// Bench for pipe_io_in_cond (DEBOUNCE_CYCLES=4): directed test-plan steps, then random bouncy
// stimulus compared every edge against a run-length reference model.
module tb_pipe_io_in_cond;

   localparam int W = 10;
   localparam int D = 4;

   logic         clock = 1'b0;
   logic         resetn;
   logic [W-1:0] sw_raw;
   logic [W-1:0] flag_clr;
   logic [W-1:0] io_in;
   logic         io_chg;
   logic [W-1:0] io_chg_mask;
   logic [W-1:0] rise_flags;
   logic [W-1:0] fall_flags;

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic [W-1:0] m_s1, m_s2, m_io, m_mask, m_rise, m_fall;
   logic         m_chg;
   int           m_run [W];

   pipe_io_in_cond #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .sw_raw     (sw_raw),
      .io_in      (io_in),
      .io_chg     (io_chg),
      .io_chg_mask(io_chg_mask),
      .flag_clr   (flag_clr),
      .rise_flags (rise_flags),
      .fall_flags (fall_flags)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // A bit is accepted once it has disagreed with the stable value for D edges in a row;
   // acceptance flips the stable bit. sync2 is the raw value delayed two edges.
   task automatic model_update();
      logic [W-1:0] acc;
      logic [W-1:0] nio;
      if (!resetn) begin
         m_s1 = '0; m_s2 = '0; m_io = '0; m_mask = '0; m_chg = 1'b0;
         m_rise = '0; m_fall = '0;
         for (int i = 0; i < W; i++) m_run[i] = 0;
      end else begin
         acc = '0;
         for (int i = 0; i < W; i++) begin
            if (m_s2[i] !== m_io[i]) begin
               m_run[i] = m_run[i] + 1;
               if (m_run[i] == D) begin
                  acc[i]   = 1'b1;
                  m_run[i] = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
         nio    = m_io ^ acc;
         m_mask = acc;
         m_chg  = (acc != '0);
`ifdef IO_EDGE_LATCH_EN
         m_rise = (m_rise & ~flag_clr) | (acc &  nio);
         m_fall = (m_fall & ~flag_clr) | (acc & ~nio);
`else
         m_rise = '0;
         m_fall = '0;
`endif
         m_io = nio;
         m_s2 = m_s1;
         m_s1 = sw_raw;
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_update();
      #1;
      check("model_io_in", 32'(io_in), 32'(m_io));
      check("model_io_chg", 32'(io_chg), 32'(m_chg));
      check("model_chg_mask", 32'(io_chg_mask), 32'(m_mask));
      check("model_rise", 32'(rise_flags), 32'(m_rise));
      check("model_fall", 32'(fall_flags), 32'(m_fall));
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   logic [W-1:0] exp_rise, exp_fall;
   int           pulses;

   initial begin
      resetn   = 1'b0;
      sw_raw   = '0;
      flag_clr = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
      m_s1 = '0; m_s2 = '0; m_io = '0; m_mask = '0; m_chg = 1'b0; m_rise = '0; m_fall = '0;

      // 1: reset then clean press of bit 0
      ticks(2);
      check("reset_io_in", 32'(io_in), 32'h0);
      check("reset_chg", 32'(io_chg), 32'h0);
      check("reset_mask", 32'(io_chg_mask), 32'h0);
      check("reset_flags", 32'(rise_flags | fall_flags), 32'h0);
      resetn = 1'b1;
      sw_raw = 10'h001;
      tick();
      for (int e = 1; e <= 4; e++) begin
         tick();
         check("press_hold_low", 32'(io_in), 32'h0);
      end
      tick();
      check("press_io_in", 32'(io_in), 32'h001);
      check("press_chg", 32'(io_chg), 32'h1);
      check("press_mask", 32'(io_chg_mask), 32'h001);
      tick();
      check("press_chg_drop", 32'(io_chg), 32'h0);
      check("press_mask_drop", 32'(io_chg_mask), 32'h0);

      // 2: bounce on bit 3, then hold
      pulses = 0;
      for (int t = 0; t < 4; t++) begin
         sw_raw = (t % 2 == 0) ? 10'h009 : 10'h001;
         tick();
         if (io_chg) pulses++;
      end
      sw_raw = 10'h009;
      tick();
      for (int e = 1; e <= 4; e++) begin
         tick();
         if (io_chg) pulses++;
         check("bounce_bit3_low", 32'(io_in[3]), 32'h0);
      end
      tick();
      if (io_chg) pulses++;
      check("bounce_bit3_high", 32'(io_in[3]), 32'h1);
      check("bounce_mask", 32'(io_chg_mask), 32'h008);
      tick();
      check("bounce_single_pulse", 32'(pulses), 32'h1);

      // 3: simultaneous bits
      sw_raw = 10'h000;
      ticks(8);
      check("settle_zero", 32'(io_in), 32'h0);
      sw_raw = 10'h2A0;
      tick();
      for (int e = 1; e <= 4; e++) begin
         tick();
         check("simul_no_chg", 32'(io_chg), 32'h0);
      end
      tick();
      check("simul_chg", 32'(io_chg), 32'h1);
      check("simul_mask", 32'(io_chg_mask), 32'h2A0);
      check("simul_io_in", 32'(io_in), 32'h2A0);

      // 4: reset in the middle of a count
      sw_raw = 10'h000;
      ticks(8);
      sw_raw = 10'h3FF;
      ticks(4);
      check("mid_no_accept", 32'(io_in), 32'h0);
      resetn = 1'b0;
      tick();
      check("mid_reset_io_in", 32'(io_in), 32'h0);
      resetn = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         tick();
         check("mid_restart_low", 32'(io_in), 32'h0);
      end
      tick();
      check("mid_restart_io_in", 32'(io_in), 32'h3FF);
      check("mid_restart_chg", 32'(io_chg), 32'h1);

      // 5/6: edge flags with set-wins-over-clear
      flag_clr = 10'h3FF;
      tick();
      flag_clr = '0;
      sw_raw   = 10'h000;
      ticks(8);
      flag_clr = 10'h3FF;
      tick();
      flag_clr = '0;
      sw_raw   = 10'h001;
      ticks(7);
`ifdef IO_EDGE_LATCH_EN
      exp_rise = 10'h001;
`else
      exp_rise = 10'h000;
`endif
      check("flag_rise_set", 32'(rise_flags), 32'(exp_rise));
      check("flag_io_in_rise", 32'(io_in), 32'h001);
      sw_raw = 10'h000;
      ticks(5);
      flag_clr = 10'h001;
      tick();
      flag_clr = '0;
`ifdef IO_EDGE_LATCH_EN
      exp_fall = 10'h001;
`else
      exp_fall = 10'h000;
`endif
      check("flag_rise_cleared", 32'(rise_flags), 32'h0);
      check("flag_fall_set_wins", 32'(fall_flags), 32'(exp_fall));
      check("flag_fall_chg", 32'(io_chg), 32'h1);
      check("flag_fall_io_in", 32'(io_in), 32'h000);

      // random bouncy stimulus, occasional clears and resets
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(7) == 0) sw_raw = W'($urandom);
         else if ($urandom_range(3) == 0) sw_raw = sw_raw ^ (W'(1) << $urandom_range(W - 1));
         flag_clr = ($urandom_range(3) == 0) ? W'($urandom) : '0;
         resetn   = ($urandom_range(199) != 0);
         tick();
      end
      resetn   = 1'b1;
      flag_clr = '0;
      ticks(10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
